alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 41 ++++
 rtl/alu_arb_pick.sv | 19 +
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and operation codes for alu and alu_arbiter.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_OR   = 4'h2;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_SLTU = 4'h5;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h6;
    localparam logic [OP_W-1:0] OP_SRL  = 4'h7;
    localparam logic [OP_W-1:0] OP_SRA  = 4'h8;
    localparam logic [OP_W-1:0] OP_SLL  = 4'h9;
    localparam logic [OP_W-1:0] OP_SLA  = 4'hA;
    localparam logic [OP_W-1:0] OP_SGEU = 4'hB;
    localparam logic [OP_W-1:0] OP_SGE  = 4'hC;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter; undefined op codes return zero.
module alu #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] result
);
    import alu_pkg::*;

    logic [4:0] sh;
    logic       lt_u;
    logic       lt_s;

    always_comb begin
        sh     = y[4:0];
        lt_u   = x < y;
        lt_s   = $signed(x) < $signed(y);
        result = '0;
        case (op)
            OP_ADD:  result = x + y;
            OP_SUB:  result = x - y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_AND:  result = x & y;
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, lt_u};
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SRL:  result = x >> sh;
            OP_SRA:  result = DATA_W'($signed(x) >>> sh);
            OP_SLL:  result = x << sh;
            // arithmetic left shift fills with zeros, same as logical
            OP_SLA:  result = x << sh;
            OP_SGEU: result = {{(DATA_W-1){1'b0}}, ~lt_u};
            OP_SGE:  result = {{(DATA_W-1){1'b0}}, ~lt_s};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_pick.sv
// One-hot grant between two eligible ports; pointer names the preferred port.
module alu_arb_pick (
    input  logic [1:0] eligible,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (pointer && eligible[1]) begin
            grant = 2'b10;
        end else if (eligible[0]) begin
            grant = 2'b01;
        end else if (eligible[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end sharing one ALU with 1-cycle registered response slots.
// Define ALU_ARBITER_RR_EN for round-robin; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result
);
    import alu_pkg::*;

    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              pointer;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_result;

    // A full slot is still eligible when it drains in the same cycle.
    assign eligible[0] = reset_n & req0_valid & (~rsp0_valid | rsp0_ready);
    assign eligible[1] = reset_n & req1_valid & (~rsp1_valid | rsp1_ready);

    alu_arb_pick u_pick (
        .eligible (eligible),
        .pointer  (pointer),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign alu_op = grant[1] ? req1_op : req0_op;
    assign alu_x  = grant[1] ? req1_x  : req0_x;
    assign alu_y  = grant[1] ? req1_y  : req0_y;

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op     (alu_op),
        .x      (alu_x),
        .y      (alu_y),
        .result (alu_result)
    );

`ifdef ALU_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pointer <= 1'b0;
        end else if (grant != 2'b00) begin
            pointer <= grant[0];
        end
    end
`else
    assign pointer = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
        end else begin
            if (grant[0]) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
            end else if (rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end
            if (grant[1]) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
            end else if (rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter; follows ALU_ARBITER_RR_EN to pick the arbitration model.
module tb_alu_arbiter;

`ifdef ALU_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_x, req0_y, rsp0_result;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_x, req1_y, rsp1_result;

    int n_cmp = 0;
    int n_bad = 0;
    int g0 = 0;
    int g1 = 0;
    int b0, b1;
    bit started = 1'b0;
    bit ptr_m = 1'b0;
    bit fresh0 = 1'b1;
    bit fresh1 = 1'b1;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [4:0] s;
        s = y[4:0];
        case (op)
            4'h0: return x + y;
            4'h1: return x - y;
            4'h2: return x | y;
            4'h3: return x ^ y;
            4'h4: return x & y;
            4'h5: return (x < y) ? 32'd1 : 32'd0;
            4'h6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h7: return x >> s;
            4'h8: return 32'($signed(x) >>> s);
            4'h9: return x << s;
            4'hA: return x << s;
            4'hB: return (x >= y) ? 32'd1 : 32'd0;
            4'hC: return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard monitor, sampling 3 time units after each falling edge.
    always begin
        logic       v0, v1, e0, e1;
        logic [1:0] eg;
        @(negedge clk);
        #3;
        if (!reset_n) begin
            check("rst_ready", {req1_ready, req0_ready}, 2'b00);
            q0.delete();
            q1.delete();
            ptr_m   = 1'b0;
            fresh0  = 1'b1;
            fresh1  = 1'b1;
            started = 1'b1;
        end else if (started) begin
            v0 = (q0.size() != 0);
            v1 = (q1.size() != 0);
            check("rsp0_valid", rsp0_valid, v0);
            check("rsp1_valid", rsp1_valid, v1);
            if (v0) check("rsp0_result", rsp0_result, q0[0]);
            else if (fresh0) check("rsp0_rst_result", rsp0_result, 0);
            if (v1) check("rsp1_result", rsp1_result, q1[0]);
            else if (fresh1) check("rsp1_rst_result", rsp1_result, 0);

            e0 = req0_valid && (!v0 || rsp0_ready);
            e1 = req1_valid && (!v1 || rsp1_ready);
            if (e0 && e1) eg = (RR && ptr_m) ? 2'b10 : 2'b01;
            else          eg = {e1, e0 && !e1 ? 1'b1 : e0};
            check("grant", {req1_ready, req0_ready}, eg);

            if (v0 && rsp0_ready) void'(q0.pop_front());
            if (v1 && rsp1_ready) void'(q1.pop_front());
            if (eg[0]) begin q0.push_back(model(req0_op, req0_x, req0_y)); fresh0 = 1'b0; end
            if (eg[1]) begin q1.push_back(model(req1_op, req1_x, req1_y)); fresh1 = 1'b0; end
            if (eg != 2'b00) ptr_m = eg[0];
            if (req0_ready) g0++;
            if (req1_ready) g1++;
        end
    end

    task automatic set0(input bit v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        req0_valid = v; req0_op = op; req0_x = x; req0_y = y;
    endtask

    task automatic set1(input bit v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        req1_valid = v; req1_op = op; req1_x = x; req1_y = y;
    endtask

    initial begin
        reset_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set0(0, 4'h0, 0, 0);
        set1(0, 4'h0, 0, 0);
        repeat (3) @(negedge clk);

        // first cycle out of reset: ADD 5+7 on port 0
        reset_n = 1'b1;
        set0(1, 4'h0, 32'd5, 32'd7);
        #4 check("a_ready0", req0_ready, 1);
        @(negedge clk);
        set0(0, 4'h0, 0, 0);
        #4 check("a_valid0", rsp0_valid, 1);
        check("a_result0", rsp0_result, 32'd12);

        // both ports busy every cycle, fresh pointer
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        b0 = g0;
        b1 = g1;
        for (int i = 0; i < 8; i++) begin
            set0(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            set1(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            if (i == 0) #4 check("b_first", {req1_ready, req0_ready}, 2'b01);
            @(negedge clk);
        end
        set0(0, 4'h0, 0, 0);
        set1(0, 4'h0, 0, 0);
        #4 check("b_grants0", g0 - b0, RR ? 4 : 8);
        check("b_grants1", g1 - b1, RR ? 4 : 0);

        // port 1 SRA result held while its consumer stalls
        @(negedge clk);
        rsp1_ready = 1'b0;
        set1(1, 4'h8, 32'h8000_0000, 32'h24);
        #4 check("c_ready1", req1_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set1(1, 4'h0, 32'd3, 32'd4);
            set0(1, 4'h3, $urandom, $urandom);
            #4 check("c_blocked1", req1_ready, 0);
            check("c_valid1", rsp1_valid, 1);
            check("c_held1", rsp1_result, 32'hF800_0000);
            check("c_port0_free", req0_ready, 1);
        end
        @(negedge clk);
        set0(0, 4'h0, 0, 0);
        rsp1_ready = 1'b1;
        #4 check("c_drain_refill1", req1_ready, 1);
        @(negedge clk);
        set1(0, 4'h0, 0, 0);
        #4 check("c_valid_refill1", rsp1_valid, 1);
        check("c_result_refill1", rsp1_result, 32'd7);
        @(negedge clk);
        #4 check("c_drained1", rsp1_valid, 0);

        // comparisons and an undefined op, back to back
        @(negedge clk);
        set0(1, 4'h6, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        set0(1, 4'h5, 32'hFFFF_FFFF, 32'd1);
        #4 check("d_slt", rsp0_result, 32'd1);
        @(negedge clk);
        set0(1, 4'hE, $urandom, $urandom);
        #4 check("d_sltu", rsp0_result, 32'd0);
        @(negedge clk);
        set0(0, 4'h0, 0, 0);
        #4 check("d_undef_valid", rsp0_valid, 1);
        check("d_undef_result", rsp0_result, 32'd0);

        // random traffic with random back-pressure
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            set0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            set1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end

        // reset right after a grant discards the results
        @(negedge clk);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set0(1, 4'h0, 32'd1, 32'd2);
        set1(0, 4'h0, 0, 0);
        #4 check("f_grant0", req0_ready, 1);
        @(negedge clk);
        reset_n = 1'b0;
        set1(1, 4'h1, 32'd9, 32'd3);
        @(negedge clk);
        reset_n = 1'b1;
        set0(1, 4'h0, 32'd9, 32'd9);
        set1(1, 4'h0, 32'd8, 32'd8);
        #4 check("f_valid0", rsp0_valid, 0);
        check("f_valid1", rsp1_valid, 0);
        check("f_result0", rsp0_result, 0);
        check("f_result1", rsp1_result, 0);
        check("f_prefer0", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        set0(0, 4'h0, 0, 0);
        set1(0, 4'h0, 0, 0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
